score4_state_fsm: RTL and testbench

SCORE4_STATE_FSM -- requirements
Module: score4_state_fsm

---
 rtl/score4_pkg.sv | 27 ++
 rtl/score4_state_fsm_if.sv | 17 +
 rtl/score4_win_detect.sv | 74 +++++++
 rtl/score4_state_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_score4_state_fsm.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score4_pkg.sv
// -----------------------------------------------------------------------------
// score4_pkg
// Shared types and default geometry for the score4 (connect-four) game block.
//   cell_t      : board cell code (EMPTY / RED / GREEN)
//   state_t     : game FSM states
//   DEF_COLS, DEF_ROWS, DEF_WIN_LEN : default board size and winning run length
// -----------------------------------------------------------------------------
package score4_pkg;

    localparam int DEF_COLS    = 7;
    localparam int DEF_ROWS    = 6;
    localparam int DEF_WIN_LEN = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FALL  = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/score4_state_fsm_if.sv
// -----------------------------------------------------------------------------
// score4_state_fsm_if
// Observation port for the game FSM so checkers can bind to the state.
//   state : current FSM state (driven by the master = score4_state_fsm)
// Modports: master (drives), slave (observes).
// There is no handshake on this port: state is a plain level, valid every
// cycle, with no ready/back-pressure.
// -----------------------------------------------------------------------------
interface score4_state_fsm_if;
    import score4_pkg::*;

    state_t state;

    modport master (output state);
    modport slave  (input  state);

endinterface

// File: rtl/score4_win_detect.sv
// -----------------------------------------------------------------------------
// score4_win_detect
// Combinational check for a WIN_LEN run of `colour` through the cell
// (col, row) in any of the four directions: horizontal, vertical and both
// diagonals.
// Ports:
//   board  : full board, [col][row][code]
//   col    : column of the piece just landed
//   row    : row of the piece just landed
//   colour : cell code of the piece just landed
//   win    : high when a run of at least WIN_LEN passes through (col, row)
// -----------------------------------------------------------------------------
module score4_win_detect
    import score4_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CW      = $clog2(COLS),
    parameter int RW      = $clog2(ROWS)
) (
    input  logic [COLS-1:0][ROWS-1:0][1:0] board,
    input  logic [CW-1:0]                  col,
    input  logic [RW-1:0]                  row,
    input  logic [1:0]                     colour,
    output logic                           win
);

    int   dc, dr, run, c, r;
    logic go_p, go_n;

    always_comb begin
        win  = 1'b0;
        dc   = 0;
        dr   = 0;
        run  = 0;
        c    = 0;
        r    = 0;
        go_p = 1'b0;
        go_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin dc = 1; dr = 0;  end
                1:       begin dc = 0; dr = 1;  end
                2:       begin dc = 1; dr = 1;  end
                default: begin dc = 1; dr = -1; end
            endcase
            // Count the landed piece plus matching cells walking outward in
            // both senses; each walk stops at the first mismatch or edge.
            run  = 1;
            go_p = 1'b1;
            go_n = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                c = int'(col) + k * dc;
                r = int'(row) + k * dr;
                if (go_p && c >= 0 && c < COLS && r >= 0 && r < ROWS &&
                    board[CW'(c)][RW'(r)] == colour)
                    run = run + 1;
                else
                    go_p = 1'b0;
                c = int'(col) - k * dc;
                r = int'(row) - k * dr;
                if (go_n && c >= 0 && c < COLS && r >= 0 && r < ROWS &&
                    board[CW'(c)][RW'(r)] == colour)
                    run = run + 1;
                else
                    go_n = 1'b0;
            end
            if (run >= WIN_LEN)
                win = 1'b1;
        end
    end

endmodule

// File: rtl/score4_state_fsm.sv
// -----------------------------------------------------------------------------
// score4_state_fsm
// Connect-four game controller: column selector, piece drop with a one row
// per clock fall animation, end-of-game detection.
// Optional feature macro: SCORE4_WIN_CHECK_EN builds win detection; without
// it winner is tied to 00 and the game ends only when the board is full.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   left, right         : one-cycle pulses rotating the selector (wraps)
//   drop                : one-cycle pulse dropping a piece in the selected col
//   new_game            : one-cycle pulse clearing the game (selector kept)
//   panel               : board cell codes [col][row], row 0 is the top
//   play                : one-hot selected column
//   turn                : 0 red to move, 1 green to move
//   busy                : high whenever the FSM is not in IDLE
//   over, winner        : game ended / winning cell code (00 draw or none)
//   reject              : one-cycle pulse on a drop into a full column
//   dbg                 : FSM state observation port
// -----------------------------------------------------------------------------
module score4_state_fsm
    import score4_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           left,
    input  logic                           right,
    input  logic                           drop,
    input  logic                           new_game,
    output logic [COLS-1:0][ROWS-1:0][1:0] panel,
    output logic [COLS-1:0]                play,
    output logic                           turn,
    output logic                           busy,
    output logic                           over,
    output logic [1:0]                     winner,
    output logic                           reject,
    score4_state_fsm_if.master             dbg
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef logic [COLS-1:0][ROWS-1:0][1:0] board_t;

    state_t          state_q, state_d;
    board_t          board_q, board_d;
    logic [COLS-1:0] play_q, play_d;
    logic            turn_q, turn_d;
    logic            over_q, over_d;
    logic            reject_q, reject_d;
    logic [CW-1:0]   fall_col_q, fall_col_d, sel_col;
    logic [RW-1:0]   fall_row_q, fall_row_d, fall_below;
    logic [1:0]      turn_colour;
    logic            win, top_full, cmd_single;

`ifdef SCORE4_WIN_CHECK_EN
    logic [1:0] winner_q, winner_d;
    logic [1:0] landed_colour;

    assign landed_colour = board_q[fall_col_q][fall_row_q];

    score4_win_detect #(
        .COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN), .CW(CW), .RW(RW)
    ) u_win_detect (
        .board (board_q),
        .col   (fall_col_q),
        .row   (fall_row_q),
        .colour(landed_colour),
        .win   (win)
    );
    assign winner = winner_q;
`else
    assign win    = 1'b0;
    assign winner = 2'b00;
`endif

    // Index of the one-hot selector.
    always_comb begin
        sel_col = '0;
        for (int c = 0; c < COLS; c++)
            if (play_q[c]) sel_col = CW'(c);
    end

    // The board is full exactly when every top cell is occupied.
    always_comb begin
        top_full = 1'b1;
        for (int c = 0; c < COLS; c++)
            if (board_q[c][0] == EMPTY) top_full = 1'b0;
    end

    // Exactly one of left/right/drop; any combination is ignored entirely.
    assign cmd_single  = $onehot({left, right, drop});
    assign turn_colour = turn_q ? GREEN : RED;
    assign fall_below  = fall_row_q + RW'(1);

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        play_d     = play_q;
        turn_d     = turn_q;
        over_d     = over_q;
        reject_d   = 1'b0;
        fall_col_d = fall_col_q;
        fall_row_d = fall_row_q;
`ifdef SCORE4_WIN_CHECK_EN
        winner_d   = winner_q;
`endif
        if (new_game) begin
            state_d    = IDLE;
            board_d    = '0;
            turn_d     = 1'b0;
            over_d     = 1'b0;
            fall_col_d = '0;
            fall_row_d = '0;
`ifdef SCORE4_WIN_CHECK_EN
            winner_d   = 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_single) begin
                        if (left)
                            play_d = {play_q[0], play_q[COLS-1:1]};
                        else if (right)
                            play_d = {play_q[COLS-2:0], play_q[COLS-1]};
                        else if (board_q[sel_col][0] == EMPTY) begin
                            board_d[sel_col][0] = turn_colour;
                            fall_col_d          = sel_col;
                            fall_row_d          = '0;
                            state_d             = FALL;
                        end else
                            reject_d = 1'b1;
                    end
                end
                FALL: begin
                    // Move the piece down one row while the cell below is free.
                    if (int'(fall_row_q) < ROWS - 1 &&
                        board_q[fall_col_q][fall_below] == EMPTY) begin
                        board_d[fall_col_q][fall_below] = board_q[fall_col_q][fall_row_q];
                        board_d[fall_col_q][fall_row_q] = EMPTY;
                        fall_row_d                      = fall_below;
                    end else
                        state_d = CHECK;
                end
                CHECK: begin
                    if (win) begin
`ifdef SCORE4_WIN_CHECK_EN
                        winner_d = landed_colour;
`endif
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else if (top_full) begin
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = IDLE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            board_q    <= '0;
            play_q     <= COLS'(1);
            turn_q     <= 1'b0;
            over_q     <= 1'b0;
            reject_q   <= 1'b0;
            fall_col_q <= '0;
            fall_row_q <= '0;
`ifdef SCORE4_WIN_CHECK_EN
            winner_q   <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            play_q     <= play_d;
            turn_q     <= turn_d;
            over_q     <= over_d;
            reject_q   <= reject_d;
            fall_col_q <= fall_col_d;
            fall_row_q <= fall_row_d;
`ifdef SCORE4_WIN_CHECK_EN
            winner_q   <= winner_d;
`endif
        end
    end

    assign panel     = board_q;
    assign play      = play_q;
    assign turn      = turn_q;
    assign busy      = (state_q != IDLE);
    assign over      = over_q;
    assign reject    = reject_q;
    assign dbg.state = state_q;

endmodule

// File: tb/tb_score4_state_fsm.sv
// -----------------------------------------------------------------------------
// tb_score4_state_fsm
// Directed bench for score4_state_fsm with default geometry (7 x 6, run 4).
// Expectations follow SCORE4_WIN_CHECK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_score4_state_fsm;
    import score4_pkg::*;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic clk = 1'b0;
    logic rst, left, right, drop, new_game;
    logic [COLS-1:0][ROWS-1:0][1:0] panel;
    logic [COLS-1:0][ROWS-1:0][1:0] exp_panel;
    logic [COLS-1:0] play;
    logic turn, busy, over, reject;
    logic [1:0] winner;
    logic exp_turn;
    int compared   = 0;
    int mismatched = 0;
    int cur_col    = 0;

    score4_state_fsm_if dbg_if ();

    score4_state_fsm dut (
        .clk     (clk),
        .rst     (rst),
        .left    (left),
        .right   (right),
        .drop    (drop),
        .new_game(new_game),
        .panel   (panel),
        .play    (play),
        .turn    (turn),
        .busy    (busy),
        .over    (over),
        .winner  (winner),
        .reject  (reject),
        .dbg     (dbg_if)
    );

    // ---------------- clock / reset support ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_right();
        right = 1'b1;
        step();
        right = 1'b0;
    endtask

    task automatic pulse_left();
        left = 1'b1;
        step();
        left = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        exp_panel = '0;
        exp_turn  = 1'b0;
    endtask

    task automatic goto_col(input int c);
        while (cur_col != c) begin
            pulse_right();
            cur_col = (cur_col + 1) % COLS;
        end
        check($sformatf("goto_col%0d", c), 128'(play), 128'(1) << c);
    endtask

    // Model: place the mover's colour at the lowest empty row of cur_col.
    task automatic model_place();
        bit placed;
        placed = 1'b0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!placed && exp_panel[cur_col][r] == 2'b00) begin
                exp_panel[cur_col][r] = exp_turn ? 2'b10 : 2'b01;
                placed = 1'b1;
            end
        end
    endtask

    // Drop and wait until the FSM is back in IDLE or has ended the game.
    task automatic play_drop(input string tag);
        int n;
        drop = 1'b1;
        step();
        drop = 1'b0;
        n = 0;
        while (busy && dbg_if.state != DONE && n < 40) begin
            step();
            n++;
        end
        check({tag, "_settle"}, 128'(n < 40), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; left = 1'b0; right = 1'b0; drop = 1'b0; new_game = 1'b0;
        exp_panel = '0;
        exp_turn  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_panel",  128'(panel), 128'(0));
        check("rst_play",   128'(play), 128'(7'b0000001));
        check("rst_turn",   128'(turn), 128'(0));
        check("rst_busy",   128'(busy), 128'(0));
        check("rst_over",   128'(over), 128'(0));
        check("rst_winner", 128'(winner), 128'(0));
        check("rst_reject", 128'(reject), 128'(0));
        check("rst_state",  128'(dbg_if.state), 128'(IDLE));

        // Selector: wrap left, then three rights
        pulse_left();
        check("sel_wrap_left", 128'(play), 128'(7'b1000000));
        pulse_right();
        check("sel_right1", 128'(play), 128'(7'b0000001));
        pulse_right();
        check("sel_right2", 128'(play), 128'(7'b0000010));
        pulse_right();
        check("sel_right3", 128'(play), 128'(7'b0000100));
        cur_col = 2;

        // Conflicting commands are ignored
        left = 1'b1; right = 1'b1;
        step();
        left = 1'b0; right = 1'b0;
        check("sel_lr_ignored", 128'(play), 128'(7'b0000100));
        right = 1'b1; drop = 1'b1;
        step();
        right = 1'b0; drop = 1'b0;
        check("sel_rd_ignored", 128'(play), 128'(7'b0000100));
        check("sel_rd_no_drop", 128'(busy), 128'(0));

        // Fall timing in column 3 on an empty board
        goto_col(3);
        drop = 1'b1;
        step();                               // edge t
        drop = 1'b0;
        check("fall_t_top",  128'(panel[3][0]), 128'(2'b01));
        check("fall_t_busy", 128'(busy), 128'(1));
        for (int i = 1; i <= 4; i++) step();
        step();                               // edge t+5
        check("fall_t5_bottom", 128'(panel[3][5]), 128'(2'b01));
        check("fall_t5_above",  128'(panel[3][4]), 128'(2'b00));
        step();                               // edge t+6
        check("fall_t6_check", 128'(dbg_if.state), 128'(CHECK));
        step();                               // edge t+7
        check("fall_t7_busy", 128'(busy), 128'(0));
        check("fall_t7_turn", 128'(turn), 128'(1));
        exp_panel[3][5] = 2'b01;
        check("fall_panel", 128'(panel), 128'(exp_panel));

        // New game keeps the selector
        pulse_new_game();
        check("ng_panel", 128'(panel), 128'(0));
        check("ng_turn",  128'(turn), 128'(0));
        check("ng_play",  128'(play), 128'(7'b0001000));

        // Fill column 0, then reject the 7th drop
        goto_col(0);
        for (int i = 0; i < ROWS; i++) begin
            model_place();
            play_drop($sformatf("fill%0d", i));
            exp_turn = ~exp_turn;
        end
        check("fill_panel",  128'(panel), 128'(exp_panel));
        check("fill_bottom", 128'(panel[0][5]), 128'(2'b01));
        check("fill_top",    128'(panel[0][0]), 128'(2'b10));
        check("fill_turn",   128'(turn), 128'(0));
        drop = 1'b1;
        step();
        drop = 1'b0;
        check("full_reject", 128'(reject), 128'(1));
        check("full_state",  128'(dbg_if.state), 128'(IDLE));
        check("full_panel",  128'(panel), 128'(exp_panel));
        check("full_turn",   128'(turn), 128'(0));
        step();
        check("full_reject_pulse", 128'(reject), 128'(0));

        // Horizontal red run on the bottom row, green stacking in column 6
        pulse_new_game();
        goto_col(0); model_place(); play_drop("win0"); exp_turn = ~exp_turn;
        goto_col(6); model_place(); play_drop("win1"); exp_turn = ~exp_turn;
        goto_col(1); model_place(); play_drop("win2"); exp_turn = ~exp_turn;
        goto_col(6); model_place(); play_drop("win3"); exp_turn = ~exp_turn;
        goto_col(2); model_place(); play_drop("win4"); exp_turn = ~exp_turn;
        goto_col(6); model_place(); play_drop("win5"); exp_turn = ~exp_turn;
        goto_col(3); model_place(); play_drop("win6");
        check("win_panel", 128'(panel), 128'(exp_panel));
`ifdef SCORE4_WIN_CHECK_EN
        check("win_winner", 128'(winner), 128'(2'b01));
        check("win_over",   128'(over), 128'(1));
        check("win_state",  128'(dbg_if.state), 128'(DONE));
        check("win_busy",   128'(busy), 128'(1));
        check("win_turn",   128'(turn), 128'(0));
        pulse_right();
        check("done_play", 128'(play), 128'(7'b0001000));
        drop = 1'b1;
        step();
        drop = 1'b0;
        step();
        check("done_panel",  128'(panel), 128'(exp_panel));
        check("done_reject", 128'(reject), 128'(0));
`else
        exp_turn = ~exp_turn;
        check("nowin_winner", 128'(winner), 128'(2'b00));
        check("nowin_over",   128'(over), 128'(0));
        check("nowin_turn",   128'(turn), 128'(1));
        check("nowin_busy",   128'(busy), 128'(0));
        model_place(); play_drop("cont"); exp_turn = ~exp_turn;
        check("cont_cell",  128'(panel[3][4]), 128'(2'b10));
        check("cont_panel", 128'(panel), 128'(exp_panel));
        check("cont_turn",  128'(turn), 128'(0));
`endif

        // Reset in the middle of a fall
        pulse_new_game();
        goto_col(5);
        drop = 1'b1;
        step();
        drop = 1'b0;
        step();
        step();
        check("midfall_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur_col = 0;
        check("midfall_panel", 128'(panel), 128'(0));
        check("midfall_state", 128'(dbg_if.state), 128'(IDLE));
        check("midfall_busy0", 128'(busy), 128'(0));
        check("midfall_play",  128'(play), 128'(7'b0000001));
        check("midfall_turn",  128'(turn), 128'(0));

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
